keypad_scanner: RTL
===================

# keypad_scanner

Matrix-keypad reader for the 4x4 hex keypad on the board's Pmod connector, the input-side counterpart to the multiplexed seven-segment display driver. It drives one column low at a time, samples the active-low row lines, debounces across whole scan frames, and emits a single-cycle event carrying the 4-bit hex code of each clean key press. Its outputs feed the same 4-bit value path the display consumes, replacing the slide switches and the separate enter button.

## Interface
- SCAN_TICKS, 50000: clk cycles each column is driven (dwell); legal minimum 4.
- DEBOUNCE_SCANS, 8: consecutive agreeing frames required to accept a press or a release; legal minimum 1.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock and no other reset.
- row  input  4  keypad rows, active-low, asynchronous to clk (external pull-ups).
- col  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  hex code of the last accepted press; held until the next press.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from the accepted press until the accepted release.

## Operation
- Key map, row r / col c: r0 gives 1,2,3,A; r1 gives 4,5,6,B; r2 gives 7,8,9,C; r3 gives 0,F,E,D.
- row passes through a 2-flop synchronizer before any use.
- Scan order: col = 1110, 1101, 1011, 0111, repeating. The dwell counter runs 0..SCAN_TICKS-1 per column.
- Rows are sampled (synced value) only on the last dwell cycle of each column. A key is down when its row bit is 0 while its column is driven.
- Frame result, resolved after column 3 is sampled:
  - NONE: no key down.
  - ONE(code): exactly one key down.
  - MULTI: two or more keys down.
- Debounce state: prev_result plus a stable counter.
  - Counter increments when the frame result equals prev_result.
  - Counter resets to 1 otherwise, and prev_result is updated.
  - The counter saturates at DEBOUNCE_SCANS.
- FSM RELEASED:
  - Moves to PRESSED when the result is ONE(code) and the counter reaches DEBOUNCE_SCANS.
  - On that transition: key_code <= code, key_valid pulses, key_held <= 1.
- FSM PRESSED:
  - Moves to RELEASED when the result is NONE and the counter reaches DEBOUNCE_SCANS; key_held <= 0.
  - key_code is retained after release.
- MULTI never causes a transition in either state.
- ONE with a different code while PRESSED causes no event. A new press event requires an accepted release first (no rollover, no auto-repeat).

## Timing
- Reset values: col = 1110, key_code = 0, key_valid = 0, key_held = 0, FSM = RELEASED, counters = 0, prev_result = NONE, synchronizer flops = 1111.
- First scan cycle is the cycle after reset deasserts. reset asserted mid-operation behaves identically.
- A key still physically held through reset produces a fresh press event after debounce.
- Frame length is 4*SCAN_TICKS cycles.
- key_valid and the key_held rise are registered and appear the cycle after the frame's final sample.
- key_code updates in the same cycle key_valid is high.
- Press latency from a stable row change is at most (DEBOUNCE_SCANS+1) frames + 3 cycles.
- Dwell and column counters wrap silently.
- Dwell counter width is $clog2(SCAN_TICKS). Debounce counter width is $clog2(DEBOUNCE_SCANS+1).

## Structure
- Package keypad_pkg holds:
  - Column drive constants (1110, 1101, 1011, 0111).
  - The 16-entry key-code table indexed {row, col}.
  - The frame-result enum NONE/ONE/MULTI.
  - The FSM state enum RELEASED/PRESSED.
- One sub-module, row_sync: the 4-bit 2-flop synchronizer with synchronous reset to 1111.

## Test plan
Bench parameters: SCAN_TICKS=4, DEBOUNCE_SCANS=3, frame = 16 cycles. The keypad model pulls a row low while its key is down and its column is driven low.
- Idle after reset: col cycles 1110, 1101, 1011, 0111 at 4 cycles each. key_valid never asserts, and key_held and key_code stay 0.
- Press '5' (r1, c1) held 100 cycles: exactly one key_valid pulse with key_code = 4'h5, within 4 frames + 3 cycles of the press. key_held stays 1.
- Release '5' and wait 64 cycles: key_held falls within 4 frames + 3 cycles, key_code stays 4'h5, and no key_valid pulse occurs.
- Bounce: toggle the 'D' key (r3, c3) every 5 cycles for 40 cycles, then hold it. No pulse occurs during bouncing, then one pulse with key_code = 4'hD after stabilization.
- Press '1' and '9' together for 100 cycles: no key_valid. Then release '9' only: one pulse with key_code = 4'h1.
- Hold 'A' until key_held = 1, then assert reset for 1 cycle while 'A' stays down: all outputs return to reset values, then one new pulse with key_code = 4'hA after debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Indexed {row, col}; row r / col c maps to the printed legend on the pad.
  localparam logic [3:0] KEY_TABLE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } result_t;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad row lines.
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] row_synced
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta       <= '1;
      row_synced <= '1;
    end else begin
      meta       <= row;
      row_synced <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with frame-level debounce and single-cycle press events.
module keypad_scanner #(
  parameter int unsigned SCAN_TICKS     = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int unsigned DW  = $clog2(SCAN_TICKS);
  localparam int unsigned DBW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam logic [DBW-1:0] DB_MAX     = DBW'(DEBOUNCE_SCANS);

  logic [3:0]     row_s;
  logic [DW-1:0]  dwell;
  logic [1:0]     col_idx;
  logic [1:0]     acc_cnt;
  logic [3:0]     acc_code;
  result_t        prev_result;
  logic [3:0]     prev_code;
  logic [DBW-1:0] stable;
  state_t         state;

  logic [1:0]     frame_cnt;
  logic [3:0]     frame_code;
  result_t        frame_result;
  logic           same;
  logic [DBW-1:0] stable_next;
  logic           sample;
  logic           frame_end;

  row_sync u_row_sync (
    .clk        (clk),
    .reset      (reset),
    .row        (row),
    .row_synced (row_s)
  );

  assign col       = COL_DRIVE[col_idx];
  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (col_idx == 2'd3);

  // Running frame tally including the current column; column 0 starts a fresh frame.
  // The count saturates at 2 since only "one" versus "several" matters.
  always_comb begin
    frame_cnt  = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    frame_code = (col_idx == 2'd0) ? 4'h0 : acc_code;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        frame_code = KEY_TABLE[{2'(r), col_idx}];
        if (frame_cnt != 2'd2) frame_cnt = frame_cnt + 2'd1;
      end
    end
    case (frame_cnt)
      2'd0:    frame_result = NONE;
      2'd1:    frame_result = ONE;
      default: frame_result = MULTI;
    endcase
    same = (frame_result == prev_result) &&
           ((frame_result != ONE) || (frame_code == prev_code));
    if (!same)                stable_next = DBW'(1);
    else if (stable == DB_MAX) stable_next = stable;
    else                      stable_next = stable + DBW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell       <= '0;
      col_idx     <= '0;
      acc_cnt     <= '0;
      acc_code    <= '0;
      prev_result <= NONE;
      prev_code   <= '0;
      stable      <= '0;
      state       <= RELEASED;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sample) begin
        dwell    <= '0;
        col_idx  <= col_idx + 2'd1;
        acc_cnt  <= frame_cnt;
        acc_code <= frame_code;
      end else begin
        dwell <= dwell + DW'(1);
      end
      if (frame_end) begin
        prev_result <= frame_result;
        prev_code   <= frame_code;
        stable      <= stable_next;
        case (state)
          RELEASED: begin
            if (frame_result == ONE && stable_next == DB_MAX) begin
              state     <= PRESSED;
              key_code  <= frame_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end
          end
          PRESSED: begin
            if (frame_result == NONE && stable_next == DB_MAX) begin
              state    <= RELEASED;
              key_held <= 1'b0;
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule
